// File: rtl/dmem_bridge_pkg.sv
// Shared types and defaults for the data-memory bridge between the MIPS
// datapath and a variable-latency memory port.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} dmem_state_t;

  localparam int unsigned DMEM_TIMEOUT = 255;

  function automatic logic is_aligned(input logic [31:0] a);
    return (a[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// Request/ready + rvalid memory handshake seen from the bridge (master)
// and from the memory (slave).
interface dmem_bridge_if;

  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  modport master (
    output m_req, m_we, m_addr, m_wdata,
    input  m_ready, m_rvalid, m_rdata
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata,
    output m_ready, m_rvalid, m_rdata
  );

endinterface

// File: rtl/dmem_bridge_timeout_cnt.sv
// Cycle counter for an outstanding memory access; hit flags the cycle in
// which the count reaches TIMEOUT so the bridge can abandon the access.
module timeout_cnt
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT = DMEM_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_reg;

  // Saturates at TIMEOUT so a late-accepted read still times out in WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && (count_reg != CW'(TIMEOUT))) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign hit = en && (count_reg >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns the datapath's lw/sw into a req/ready + rvalid
// transaction and stalls the core until the access completes.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT = DMEM_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memread,
  input  logic          memwrite,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          stall,
  output logic          err,
  dmem_bridge_if.master mem
);

  dmem_state_t state_reg, state_next;

  logic        req_we_reg;
  logic [31:0] req_addr_reg;
  logic [31:0] req_wdata_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;

  logic        access;
  logic        aligned;
  logic        capture;
  logic        drop;
  logic        set_err;
  logic        rd_load;
  logic [31:0] rd_value;
  logic        cnt_clr;
  logic        cnt_en;
  logic        cnt_hit;
  logic        req_now;

  assign access  = memread | memwrite;
  assign aligned = is_aligned(addr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A completed handshake takes priority over a timeout in the same cycle.
  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    req_now    = 1'b0;
    capture    = 1'b0;
    drop       = 1'b0;
    set_err    = 1'b0;
    rd_load    = 1'b0;
    rd_value   = '0;
    cnt_clr    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (access) begin
          if (aligned) begin
            capture    = 1'b1;
            cnt_clr    = 1'b1;
            stall      = 1'b1;
            state_next = REQ;
          end else begin
            drop    = 1'b1;
            set_err = 1'b1;
          end
        end
      end
      REQ: begin
        req_now = 1'b1;
        stall   = 1'b1;
        if (mem.m_ready) begin
          state_next = req_we_reg ? DONE : WAIT;
        end else if (cnt_hit) begin
          set_err    = 1'b1;
          rd_load    = 1'b1;
          state_next = DONE;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (mem.m_rvalid) begin
          rd_load    = 1'b1;
          rd_value   = mem.m_rdata;
          state_next = DONE;
        end else if (cnt_hit) begin
          set_err    = 1'b1;
          rd_load    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign cnt_en = (state_reg == REQ) || (state_reg == WAIT);

  timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .hit   (cnt_hit)
  );

  // memwrite wins when both strobes are set, so a dual strobe is a store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_we_reg    <= 1'b0;
      req_addr_reg  <= '0;
      req_wdata_reg <= '0;
    end else if (capture) begin
      req_we_reg    <= memwrite;
      req_addr_reg  <= {addr[31:2], 2'b00};
      req_wdata_reg <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_reg <= '0;
    end else if (rd_load) begin
      rdata_reg <= rd_value;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_reg <= 1'b0;
    end else if (set_err) begin
      err_reg <= 1'b1;
    end
  end

  assign mem.m_req   = req_now;
  assign mem.m_we    = req_we_reg;
  assign mem.m_addr  = req_addr_reg;
  assign mem.m_wdata = req_wdata_reg;

  assign rdata = drop ? '0 : rdata_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed scenarios plus randomized
// loads/stores against a word-array reference model of memory.
module tb_dmem_bridge;

  localparam int TO = 8;

  logic        clk;
  logic        reset;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        err;

  dmem_bridge_if mem_if ();

  dmem_bridge #(
    .TIMEOUT (TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .memread  (memread),
    .memwrite (memwrite),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .stall    (stall),
    .err      (err),
    .mem      (mem_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  logic [31:0] mem_arr [64];
  logic [31:0] ref_arr [64];
  logic [31:0] last_rd;
  logic        exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Core + memory responder: presents one instruction, answers m_req after
  // d request cycles and returns read data r cycles after acceptance.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input int d, input int r,
                            output int stall_n, output int req_n, output int cyc_n,
                            output logic [31:0] done_rd, output int acc_n,
                            output logic [31:0] acc_addr, output logic acc_we,
                            output logic [31:0] acc_wdata, output logic stable_ok);
    int   acc_cyc;
    logic done;
    logic [31:0] f_addr, f_wdata;
    logic f_we;
    stall_n = 0; req_n = 0; cyc_n = 0; acc_n = 0; done = 1'b0; acc_cyc = -1;
    done_rd = '0; acc_addr = '0; acc_we = 1'b0; acc_wdata = '0; stable_ok = 1'b1;
    f_addr = '0; f_wdata = '0; f_we = 1'b0;
    memread = rd; memwrite = wr; addr = a; wdata = wd;
    while (!done && cyc_n < 64) begin
      #1;
      mem_if.m_ready  = 1'b0;
      mem_if.m_rvalid = 1'b0;
      mem_if.m_rdata  = $urandom;
      if (mem_if.m_req) begin
        req_n++;
        if (req_n == 1) begin
          f_addr = mem_if.m_addr; f_we = mem_if.m_we; f_wdata = mem_if.m_wdata;
        end else if (mem_if.m_addr !== f_addr || mem_if.m_we !== f_we || mem_if.m_wdata !== f_wdata) begin
          stable_ok = 1'b0;
        end
        if (acc_cyc < 0 && req_n - 1 == d) begin
          mem_if.m_ready = 1'b1;
          acc_cyc   = cyc_n;
          acc_n++;
          acc_addr  = mem_if.m_addr;
          acc_we    = mem_if.m_we;
          acc_wdata = mem_if.m_wdata;
          if (mem_if.m_we) mem_arr[mem_if.m_addr[7:2]] = mem_if.m_wdata;
        end
      end
      if (acc_cyc < 0 || acc_cyc == cyc_n) begin
        mem_if.m_rvalid = 1'($urandom_range(0, 1));
      end else if (!acc_we && cyc_n == acc_cyc + r) begin
        mem_if.m_rvalid = 1'b1;
        mem_if.m_rdata  = mem_arr[acc_addr[7:2]];
      end
      if (stall) begin
        stall_n++;
      end else begin
        done    = 1'b1;
        done_rd = rdata;
      end
      cyc_n++;
      @(posedge clk);
      @(negedge clk);
    end
    memread = 1'b0; memwrite = 1'b0;
    mem_if.m_ready = 1'b0; mem_if.m_rvalid = 1'b0;
  endtask

  task automatic check_access(input string tag, input logic rd, input logic wr,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int d, input int r, output int cyc);
    int stall_n, req_n, acc_n, exp_stall, exp_req, exp_acc;
    logic [31:0] done_rd, acc_addr, acc_wdata, exp_rd;
    logic acc_we, stable_ok, mem_op, ok_align;
    mem_op   = rd | wr;
    ok_align = (a[1:0] == 2'b00);
    run_access(rd, wr, a, wd, d, r, stall_n, req_n, cyc, done_rd, acc_n,
               acc_addr, acc_we, acc_wdata, stable_ok);
    if (!mem_op) begin
      exp_stall = 0; exp_req = 0; exp_acc = 0; exp_rd = last_rd;
    end else if (!ok_align) begin
      exp_stall = 0; exp_req = 0; exp_acc = 0; exp_rd = '0; exp_err = 1'b1;
    end else if (d >= TO) begin
      exp_stall = TO + 1; exp_req = TO; exp_acc = 0; exp_rd = '0;
      last_rd = '0; exp_err = 1'b1;
    end else if (wr) begin
      exp_stall = d + 2; exp_req = d + 1; exp_acc = 1; exp_rd = last_rd;
      ref_arr[a[7:2]] = wd;
    end else begin
      exp_stall = d + r + 2; exp_req = d + 1; exp_acc = 1;
      exp_rd = ref_arr[a[7:2]]; last_rd = exp_rd;
    end
    chk({tag, "/stall_cycles"}, stall_n, exp_stall);
    chk({tag, "/req_cycles"}, req_n, exp_req);
    chk({tag, "/accepts"}, acc_n, exp_acc);
    chk({tag, "/rdata"}, done_rd, exp_rd);
    chk({tag, "/err"}, {31'b0, err}, {31'b0, exp_err});
    if (exp_acc == 1) begin
      chk({tag, "/m_addr"}, acc_addr, {a[31:2], 2'b00});
      chk({tag, "/m_we"}, {31'b0, acc_we}, {31'b0, wr});
      chk({tag, "/stable"}, {31'b0, stable_ok}, 32'd1);
      if (wr) chk({tag, "/m_wdata"}, acc_wdata, wd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc_a, cyc_b;
    logic [31:0] a;
    logic [5:0]  idx;
    int kind;
    reset = 1'b0; memread = 1'b0; memwrite = 1'b0; addr = '0; wdata = '0;
    mem_if.m_ready = 1'b0; mem_if.m_rvalid = 1'b0; mem_if.m_rdata = '0;
    last_rd = '0; exp_err = 1'b0;
    for (int i = 0; i < 64; i++) begin
      mem_arr[i] = $urandom;
      ref_arr[i] = mem_arr[i];
    end

    // Reset values
    #3;
    chk("reset/m_req", {31'b0, mem_if.m_req}, 32'd0);
    chk("reset/m_we", {31'b0, mem_if.m_we}, 32'd0);
    chk("reset/m_addr", mem_if.m_addr, 32'd0);
    chk("reset/m_wdata", mem_if.m_wdata, 32'd0);
    chk("reset/rdata", rdata, 32'd0);
    chk("reset/err", {31'b0, err}, 32'd0);
    chk("reset/stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Aligned store, memory ready at once
    check_access("store", 1'b0, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 0, 1, cyc_a);
    $display("store 0x10: %0d cycles", cyc_a);
    chk("store/total_cycles", cyc_a, 32'd3);

    // Load with rvalid at cycle 4
    mem_arr[8] = 32'h1234_5678; ref_arr[8] = 32'h1234_5678;
    check_access("load_lat", 1'b1, 1'b0, 32'h0000_0020, 32'h0, 0, 3, cyc_a);
    $display("load 0x20: %0d cycles", cyc_a);
    chk("load_lat/total_cycles", cyc_a, 32'd6);

    // Non-memory instruction
    check_access("nonmem", 1'b0, 1'b0, 32'h0000_0044, 32'h0, 0, 1, cyc_a);
    chk("nonmem/total_cycles", cyc_a, 32'd1);

    // Back-to-back sw then lw of the same word
    check_access("b2b_sw", 1'b0, 1'b1, 32'h0000_0030, 32'hA5A5_0F0F, 0, 1, cyc_a);
    check_access("b2b_lw", 1'b1, 1'b0, 32'h0000_0030, 32'h0, 0, 1, cyc_b);
    $display("back-to-back sw/lw: %0d cycles", cyc_a + cyc_b);
    chk("b2b/total_cycles", cyc_a + cyc_b, 32'd7);

    // Randomized aligned traffic, including dual-strobe stores
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      idx  = 6'($urandom_range(0, 63));
      a    = {24'b0, idx, 2'b00};
      check_access("rand", (kind >= 6) || (kind == 1), (kind >= 1) && (kind <= 5),
                   a, $urandom, $urandom_range(0, 2), $urandom_range(1, 4), cyc_a);
      $display("rand %0d kind %0d addr %h: %0d cycles", i, kind, a, cyc_a);
    end

    // Misaligned load, then err must stay set
    check_access("misaligned", 1'b1, 1'b0, 32'h0000_0022, 32'h0, 0, 1, cyc_a);
    $display("misaligned 0x22: %0d cycles", cyc_a);
    check_access("after_mis", 1'b0, 1'b1, 32'h0000_0040, 32'h0BAD_F00D, 1, 1, cyc_a);
    check_access("after_mis_ld", 1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, 2, cyc_a);

    // Timeout: memory never accepts
    check_access("timeout", 1'b1, 1'b0, 32'h0000_0050, 32'h0, 1000, 1, cyc_a);
    $display("timeout load: %0d cycles", cyc_a);

    // Reset while the load waits for rvalid
    memread = 1'b1; addr = 32'h0000_0020; mem_if.m_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    mem_if.m_ready = 1'b0;
    #1;
    chk("rst_wait/stall_before", {31'b0, stall}, 32'd1);
    reset = 1'b0; memread = 1'b0;
    #1;
    chk("rst_wait/m_req", {31'b0, mem_if.m_req}, 32'd0);
    chk("rst_wait/stall", {31'b0, stall}, 32'd0);
    chk("rst_wait/rdata", rdata, 32'd0);
    chk("rst_wait/err", {31'b0, err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    mem_if.m_rvalid = 1'b1; mem_if.m_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_wait/late_stall", {31'b0, stall}, 32'd0);
      chk("rst_wait/late_rdata", rdata, 32'd0);
      chk("rst_wait/late_m_req", {31'b0, mem_if.m_req}, 32'd0);
      @(negedge clk);
      mem_if.m_rvalid = 1'b0;
    end
    $display("reset in WAIT: late rvalid ignored check done");
    last_rd = '0; exp_err = 1'b0;
    check_access("post_reset", 1'b1, 1'b0, 32'h0000_0030, 32'h0, 2, 2, cyc_a);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory bridge between the single-cycle MIPS datapath and a variable-latency memory port. Takes the datapath's ALU address and store data and issues the access on a req/ready + rvalid handshake. Stalls the core (PC and register-file write) until the access completes, then hands back the load word. Sits directly downstream of the datapath's `aluout`/`writedata` and upstream of its `readdata`.

## Interface
- `TIMEOUT`, default 255: maximum cycles spent in REQ+WAIT before the access is abandoned.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `memread`  in  1  load in the current instruction (lw).
- `memwrite`  in  1  store in the current instruction (sw).
- `addr`  in  32  byte address from the datapath ALU result.
- `wdata`  in  32  store data from the datapath register-file port B.
- `rdata`  out  32  load word to the datapath `readdata`.
- `stall`  out  1  1 = core must hold PC and suppress regwrite/memwrite commit this cycle.
- `err`  out  1  sticky error flag: misaligned access or timeout.
- `m_req`  out  1  request valid toward memory.
- `m_we`  out  1  1 = write request.
- `m_addr`  out  32  word-aligned request address.
- `m_wdata`  out  32  write data.
- `m_ready`  in  1  memory accepts the request this cycle.
- `m_rvalid`  in  1  read data valid.
- `m_rdata`  in  32  read data.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - `memread|memwrite` with `addr[1:0]==0`: capture `addr`, `wdata`, `we=memwrite` into request registers; go to REQ.
  - Misaligned (`addr[1:0]!=0`): no request, set `err`, stay IDLE, `stall=0`. The access is dropped and `rdata=0` is presented.
- REQ: `m_req=1`; `m_addr/m_wdata/m_we` are driven from the request registers and held stable while `m_req=1`. On `m_ready`:
  - write: go to DONE.
  - read: go to WAIT.
- WAIT: on `m_rvalid`, register `m_rdata` into the read-data register and go to DONE. `m_rvalid` is ignored in every other state.
- DONE: `stall=0`, `rdata` = read-data register. The core commits on this edge. Next state is always IDLE.
- `stall` is combinational:
  - 1 in IDLE with an aligned access requested.
  - 1 in REQ and in WAIT.
  - 0 in DONE and otherwise.
- `memread` and `memwrite` both high: treated as a write, no error.
- Timeout:
  - Counter clears on entry to REQ and increments in every REQ/WAIT cycle.
  - Reaching `TIMEOUT` sets `err`, drops `m_req`, loads 0 into the read-data register, and goes to DONE.
- `err` is cleared only by reset.
- `rdata` outside DONE: the read-data register, or 0 for a misaligned IDLE access.

## Timing
- Reset values:
  - state IDLE
  - `m_req=0`, `m_we=0`, `m_addr=0`, `m_wdata=0`
  - read-data register 0, `rdata=0`
  - `err=0`, counter 0
  - `stall=0` (no access pending)
- Reset asserted mid-access: `m_req` drops asynchronously, the access is abandoned, and a late `m_rvalid` after reset is ignored.
- Store, `m_ready` on first REQ cycle: stall in cycles 0–1, commit in cycle 2. Minimum 3 cycles per store.
- Load, `m_ready` at cycle 1, `m_rvalid` at cycle k≥2: DONE at k+1. `m_rvalid` in the same cycle as acceptance is not sampled.
- Back-to-back memory instructions: after DONE, IDLE immediately sees the next instruction's request and re-stalls. There are no idle bubbles beyond the IDLE cycle.
- Non-memory instructions: `stall=0` and 1 cycle each, as in the plain single-cycle core.

## Structure
- `dmem_pkg`: `typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} dmem_state_t;` and the default TIMEOUT constant.
- One sub-module `timeout_cnt`: parameterized counter with clear, enable, and `hit` output at `TIMEOUT`.
- Everything else (FSM, request registers, read-data register) lives in `dmem_bridge`.
- Request and read-data registers use the codebase flop style with an active-low async reset.

## Test plan
- **Aligned store:** `memwrite=1`, `addr=0x0000_0010`, `wdata=0xCAFE_F00D`, `m_ready` tied 1 → `stall` high 2 cycles; one `m_req` pulse with `m_we=1`, `m_addr=0x10`, `m_wdata=0xCAFE_F00D`; DONE in cycle 2.
- **Load with latency:** `memread=1`, `addr=0x20`, `m_ready` at cycle 1, `m_rvalid` with `0x1234_5678` at cycle 4 → `stall` high cycles 0–4; `rdata=0x1234_5678` with `stall=0` at cycle 5.
- **Misaligned load:** `addr=0x22` → `m_req` never asserts, `stall=0`, `err=1` and stays 1 through later valid accesses.
- **Timeout:** `TIMEOUT=8`, `m_ready` never asserted → `m_req` high 8 cycles then 0; `err=1`; DONE with `rdata=0`.
- **Reset in WAIT:** pull `reset` low, then return `m_rvalid=1` after release → state IDLE, all outputs 0, no DONE cycle, `rdata` remains 0.
- **Back-to-back:** sw then lw with memory ready, 1-cycle rvalid → two complete handshakes, no lost or duplicated request, total 7 cycles.
